// File: rtl/tt_pkg.sv
// ---------------------------------------------------------------------------
// tt_pkg
// Shared constants and types for the truth-table capture engine.
//   N_IN      : number of inputs of the function under test
//   TT_W      : truth-table width, 2**N_IN
//   SETTLE_W  : width of the settle-window counter (SETTLE_CYCLES <= 15)
//   cap_state_e : capture FSM states
//   tt_t, cnt_t, settle_t : table, popcount and settle-counter types
// ---------------------------------------------------------------------------
package tt_pkg;

  localparam int N_IN     = 7;
  localparam int TT_W     = 2**N_IN;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } cap_state_e;

  typedef logic [TT_W-1:0]     tt_t;
  typedef logic [N_IN:0]       cnt_t;
  typedef logic [SETTLE_W-1:0] settle_t;

endpackage

// File: rtl/tt_capture_engine_settle_timer.sv
// ---------------------------------------------------------------------------
// tt_settle_timer
// Loadable 4-bit counter that times the settle window of each input vector.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : force the count to zero (highest priority)
//   load       : load load_val
//   load_val   : value for load
//   inc        : advance the count by one
//   term       : window length in cycles
//   expired    : high in the last cycle of the window, i.e. when the
//                count about to be taken reaches term
// ---------------------------------------------------------------------------
module tt_settle_timer
  import tt_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clr,
  input  logic    load,
  input  settle_t load_val,
  input  logic    inc,
  input  settle_t term,
  output logic    expired
);

  settle_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + settle_t'(1);
    end
  end

  // Compared one bit wider so a count of 15 cannot wrap into a false match.
  assign expired = ({1'b0, cnt_q} + 5'd1) == {1'b0, term};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_capture_engine.sv
// ---------------------------------------------------------------------------
// tt_capture_engine
// Walks every input vector of an N_IN-input combinational function, samples
// its output and assembles the truth table plus its popcount.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start, x_out = 0
// SETTLE | x_out = idx, waiting SETTLE_CYCLES cycles for f_in to settle
// SAMPLE | x_out = idx, f_in captured into tt[idx] at the end of the cycle
// DONE   | tt/ones valid, result_valid held until result_ready
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a capture (only honoured in IDLE)
//   busy          : capture in progress
//   x_out         : vector applied to the function under test
//   f_in          : function output, combinational from x_out
//   result_valid  : tt/ones valid, held until accepted
//   result_ready  : consumer accepts the result
//   tt            : truth table, tt[i] = f(i)
//   ones          : popcount of tt
// ---------------------------------------------------------------------------
module tt_capture_engine #(
  parameter int N_IN          = tt_pkg::N_IN,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic [N_IN-1:0]      x_out,
  input  logic                 f_in,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [2**N_IN-1:0]   tt,
  output logic [N_IN:0]        ones
);

  localparam int TT_W = 2**N_IN;

  import tt_pkg::*;

  localparam settle_t          SETTLE_TC   = settle_t'(SETTLE_CYCLES);
  localparam logic             SKIP_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [N_IN-1:0]  IDX_LAST    = '1;

  cap_state_e        state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_IN-1:0]   x_out_q, x_out_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [N_IN:0]     ones_q, ones_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic              tmr_clr;
  logic              tmr_inc;
  logic              tmr_expired;

  tt_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (tmr_inc),
    .term     (SETTLE_TC),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_out_d = x_out_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        x_out_d = '0;
        if (start) begin
          idx_d   = '0;
          tt_d    = '0;
          ones_d  = '0;
          busy_d  = 1'b1;
          tmr_clr = 1'b1;
          state_d = SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        tmr_inc = 1'b1;
        if (tmr_expired) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        tt_d[idx_q] = f_in;
        ones_d      = ones_q + {{N_IN{1'b0}}, f_in};
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          x_out_d = '0;
        end else begin
          // x_out tracks the next index so the new vector is applied
          // in the very first cycle of its window.
          idx_d   = idx_q + 1'b1;
          x_out_d = idx_q + 1'b1;
          tmr_clr = 1'b1;
          state_d = SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
        end
      end

      ST_DONE: begin
        x_out_d = '0;
        // start is deliberately not looked at here, so a start coinciding
        // with the handshake is dropped rather than queued.
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      x_out_q <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_out_q <= x_out_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy         = busy_q;
  assign x_out        = x_out_q;
  assign result_valid = valid_q;
  assign tt           = tt_q;
  assign ones         = ones_q;

endmodule

// File: tb/tb_tt_capture_engine.sv
module tb_tt_capture_engine;

  `define CHK(TAG, OBS, EXP) \
    begin \
      checks++; \
      assert ((OBS) === (EXP)) else begin \
        failures++; \
        $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
      end \
    end

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start [3];
  logic         rr    [3];
  logic         busy  [3];
  logic [6:0]   xo    [3];
  logic         fi    [3];
  logic         rv    [3];
  logic [127:0] tt    [3];
  logic [7:0]   ones  [3];
  int           fmode [3];
  logic [1:0]   ph3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] tt;
    logic [7:0]   ones;
    int           lat;
  } exp_t;

  exp_t sb[$];

  // 0: const 0, 1: const 1, 2: majority(x0,x1,x2), 3: AND of all, 4: x0, 5: x6
  function automatic logic fval(input int m, input logic [6:0] x);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
      3:       return &x;
      4:       return x[0];
      5:       return x[6];
      default: return 1'b0;
    endcase
  endfunction

  // Position inside the 4-cycle window of the SETTLE_CYCLES=3 instance;
  // phase 3 is the sampling cycle, all other cycles get a forced 1.
  always @(posedge clk) begin
    if (rst || (start[2] && !busy[2])) ph3 <= 2'd0;
    else                               ph3 <= ph3 + 2'd1;
  end

  assign fi[0] = fval(fmode[0], xo[0]);
  assign fi[1] = fval(fmode[1], xo[1]);
  assign fi[2] = (fmode[2] == 5 && ph3 != 2'd3) ? 1'b1 : fval(fmode[2], xo[2]);

  tt_capture_engine #(.N_IN(7), .SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .x_out(xo[0]),
    .f_in(fi[0]), .result_valid(rv[0]), .result_ready(rr[0]), .tt(tt[0]), .ones(ones[0]));

  tt_capture_engine #(.N_IN(7), .SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .x_out(xo[1]),
    .f_in(fi[1]), .result_valid(rv[1]), .result_ready(rr[1]), .tt(tt[1]), .ones(ones[1]));

  tt_capture_engine #(.N_IN(7), .SETTLE_CYCLES(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .x_out(xo[2]),
    .f_in(fi[2]), .result_valid(rv[2]), .result_ready(rr[2]), .tt(tt[2]), .ones(ones[2]));

  task automatic push_exp(input logic [127:0] t, input logic [7:0] o, input int l);
    exp_t e;
    e.tt   = t;
    e.ones = o;
    e.lat  = l;
    sb.push_back(e);
  endtask

  // Returns #1 after the start-acceptance edge.
  task automatic do_start(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  // Called #1 after the acceptance edge; lat counts edges until result_valid.
  task automatic wait_done(input int d, input int budget, input int stray_at,
                           output int lat, output int busy_cnt, output int sweep_bad);
    lat       = 0;
    busy_cnt  = (busy[d] === 1'b1) ? 1 : 0;
    sweep_bad = (xo[d] === 7'd0) ? 0 : 1;
    while (rv[d] !== 1'b1 && lat < budget) begin
      start[d] = (lat == stray_at);
      @(posedge clk);
      #1;
      lat++;
      if (busy[d] === 1'b1) busy_cnt++;
      if (lat < 128 && xo[d] !== 7'(lat)) sweep_bad++;
    end
    start[d] = 1'b0;
  endtask

  task automatic check_result(input int d, input int lat, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no_expectation expected=queued_result", tag);
    end else begin
      e = sb.pop_front();
      `CHK({tag, "_valid"},   rv[d],   1'b1)
      `CHK({tag, "_tt"},      tt[d],   e.tt)
      `CHK({tag, "_ones"},    ones[d], e.ones)
      `CHK({tag, "_latency"}, lat,     e.lat)
    end
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    `CHK({tag, "_busy"},  busy[d], 1'b0)
    `CHK({tag, "_valid"}, rv[d],   1'b0)
    `CHK({tag, "_x_out"}, xo[d],   7'd0)
    `CHK({tag, "_tt"},    tt[d],   128'd0)
    `CHK({tag, "_ones"},  ones[d], 8'd0)
  endtask

  initial begin
    int lat, bc, swb, hold_bad, idle_bad;
    logic [127:0] exp_tt;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      rr[d]    = 1'b0;
      fmode[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals(0, "reset_s1");
    check_reset_vals(1, "reset_s0");
    check_reset_vals(2, "reset_s3");

    // Majority, SETTLE_CYCLES=1
    fmode[0] = 2;
    rr[0]    = 1'b1;
    do_start(0);
    push_exp({16{8'hE8}}, 8'd64, 256);
    wait_done(0, 600, -1, lat, bc, swb);
    check_result(0, lat, "maj");
    `CHK("maj_busy_cycles", bc, 256)
    @(posedge clk);
    #1;
    `CHK("maj_valid_released", rv[0], 1'b0)
    `CHK("maj_tt_kept", tt[0], {16{8'hE8}})

    // AND of all inputs, SETTLE_CYCLES=0
    fmode[1] = 3;
    rr[1]    = 1'b1;
    do_start(1);
    push_exp({1'b1, 127'd0}, 8'd1, 128);
    wait_done(1, 300, -1, lat, bc, swb);
    check_result(1, lat, "and7");
    `CHK("and7_sweep_errors", swb, 0)
    `CHK("and7_busy_cycles", bc, 128)
    @(posedge clk);
    #1;

    // Constant 0 then constant 1, back to back with result_ready high
    fmode[1] = 0;
    do_start(1);
    push_exp(128'd0, 8'd0, 128);
    wait_done(1, 300, -1, lat, bc, swb);
    check_result(1, lat, "const0");
    fmode[1] = 1;
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    `CHK("handshake_start_busy", busy[1], 1'b0)
    `CHK("handshake_start_valid", rv[1], 1'b0)
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    `CHK("restart_busy", busy[1], 1'b1)
    push_exp({128{1'b1}}, 8'd128, 128);
    wait_done(1, 300, -1, lat, bc, swb);
    check_result(1, lat, "const1");

    // Stray starts during busy and DONE, result_ready held low
    fmode[0] = 4;
    rr[0]    = 1'b0;
    exp_tt   = {32{4'hA}};
    do_start(0);
    push_exp(exp_tt, 8'd64, 256);
    wait_done(0, 600, 50, lat, bc, swb);
    check_result(0, lat, "stray_busy");
    `CHK("stray_busy_cycles", bc, 256)
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      start[0] = (i == 5);
      @(posedge clk);
      #1;
      if (rv[0] !== 1'b1 || tt[0] !== exp_tt || ones[0] !== 8'd64 || busy[0] !== 1'b0)
        hold_bad++;
    end
    start[0] = 1'b0;
    `CHK("done_hold_errors", hold_bad, 0)
    rr[0] = 1'b1;
    @(posedge clk);
    #1;
    rr[0] = 1'b0;
    `CHK("done_accept_valid", rv[0], 1'b0)
    idle_bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (busy[0] !== 1'b0 || rv[0] !== 1'b0) idle_bad++;
    end
    `CHK("no_queued_start", idle_bad, 0)
    `CHK("tt_kept_in_idle", tt[0], exp_tt)

    // Reset mid-capture, then a clean x0 capture
    rr[0] = 1'b1;
    do_start(0);
    repeat (99) @(posedge clk);
    #1;
    `CHK("partial_ones", ones[0], 8'd24)
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals(0, "midrst");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    do_start(0);
    push_exp(exp_tt, 8'd64, 256);
    wait_done(0, 600, -1, lat, bc, swb);
    check_result(0, lat, "after_rst");

    // f = x6 with settle-window glitches, SETTLE_CYCLES=3
    fmode[2] = 5;
    rr[2]    = 1'b1;
    do_start(2);
    push_exp({{64{1'b1}}, 64'd0}, 8'd64, 512);
    wait_done(2, 1000, -1, lat, bc, swb);
    check_result(2, lat, "glitch");
    `CHK("glitch_busy_cycles", bc, 512)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
